// File: rtl/mem_access_unit_pkg.sv
// mem_access_pkg: shared definitions for the load/store front-end.
//   F3_*    : RV32I funct3 encodings for loads and stores
//   state_t : control FSM states of mem_access_unit
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response handshake plus memory port bundle.
//   req_*  : load/store request from the datapath (valid/ready)
//   rsp_*  : one-cycle completion pulse with load data and error flag
//   mem_*  : word-addressed memory, combinational read, synchronous write
//   slave  : view used by mem_access_unit
//   master : view used by the datapath / memory side
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_wd, mem_we
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_wd, mem_we
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: selects the addressed byte/half of a memory word and
// sign- or zero-extends it according to funct3. Purely combinational.
//   word    : full 32-bit memory word
//   funct3  : load funct3 (undefined encodings return the whole word)
//   addr_lo : byte address bits [1:0]
//   data    : extended load result
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_HU:   data = {16'h0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end to a word-addressed memory.
// Accepts one request at a time, extends sub-word loads and performs
// read-modify-write for byte/half stores.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : mem_access_unit_if.slave (request, response and memory port)
// Optional build macro: MISALIGN_TRAP_EN -- misaligned word/half accesses
// skip the memory and respond with rsp_err=1, rsp_rdata=0.
//
//   state  | meaning
//   IDLE   | ready, waiting for req_valid
//   ACCESS | memory addressed; load captured, SW written, SB/SH merged
//   WRITE  | merged word written back (SB/SH only)
//   RESP   | rsp_valid pulse
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.slave  bus
);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   addr_q, wdata_q, merge_q, rdata_q;
    logic [XLEN-1:0]   ext_data, merge_d;
    logic [2:0]        funct3_q;
    logic              we_q;
    logic              is_byte, is_half, is_word, misaligned;
`ifdef MISALIGN_TRAP_EN
    logic              err_q;
`endif

    // Undefined encodings (011, 110, 111) fall into the word class.
    always_comb begin
        is_byte = (funct3_q[1:0] == 2'b00);
        is_half = (funct3_q[1:0] == 2'b01);
        is_word = !is_byte && !is_half;
`ifdef MISALIGN_TRAP_EN
        misaligned = (is_word && (addr_q[1:0] != 2'b00)) || (is_half && addr_q[0]);
`else
        misaligned = 1'b0;
`endif
    end

    load_extend u_load_extend (
        .word    (bus.mem_rd),
        .funct3  (funct3_q),
        .addr_lo (addr_q[1:0]),
        .data    (ext_data)
    );

    always_comb begin
        merge_d = bus.mem_rd;
        if (is_half) begin
            if (addr_q[1]) merge_d[31:16] = wdata_q[15:0];
            else           merge_d[15:0]  = wdata_q[15:0];
        end else begin
            merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (bus.req_valid) state_d = ACCESS;
            ACCESS: begin
                if (!misaligned && we_q && !is_word) state_d = WRITE;
                else                                 state_d = RESP;
            end
            WRITE:  state_d = RESP;
            RESP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // rdata_q is cleared on accept so stores and trapped accesses respond with 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (bus.req_valid) begin
                    addr_q   <= bus.req_addr;
                    wdata_q  <= bus.req_wdata;
                    funct3_q <= bus.req_funct3;
                    we_q     <= bus.req_we;
                    rdata_q  <= '0;
`ifdef MISALIGN_TRAP_EN
                    err_q    <= 1'b0;
`endif
                end
                ACCESS: begin
`ifdef MISALIGN_TRAP_EN
                    err_q <= misaligned;
`endif
                    if (!misaligned) begin
                        if (!we_q)         rdata_q <= ext_data;
                        else if (!is_word) merge_q <= merge_d;
                    end
                end
                default: ;
            endcase
        end
    end

    // mem_we depends only on registered state, so reset drops it at once.
    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.rsp_valid = (state_q == RESP);
        bus.rsp_rdata = (state_q == RESP) ? rdata_q : '0;
        bus.mem_a     = {addr_q[31:2], 2'b00};
        bus.mem_we    = 1'b0;
        bus.mem_wd    = '0;
        case (state_q)
            ACCESS: if (we_q && is_word && !misaligned) begin
                bus.mem_we = 1'b1;
                bus.mem_wd = wdata_q;
            end
            WRITE: begin
                bus.mem_we = 1'b1;
                bus.mem_wd = merge_q;
            end
            default: ;
        endcase
`ifdef MISALIGN_TRAP_EN
        bus.rsp_err = (state_q == RESP) && err_q;
`else
        bus.rsp_err = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit with a 16-word
// memory model. Requests push expected responses; a monitor pops and checks.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        preload = 1'b0;
    logic [31:0] mem [0:15];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          we_cnt = 0;
    int          rsp_cnt = 0;
    exp_t        sb_q [$];

    mem_access_unit_if bus ();

    mem_access_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus.slave)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.mem_rd = mem[bus.mem_a[5:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h8899AABB;
        end else if (bus.mem_we) begin
            mem[bus.mem_a[5:2]] <= bus.mem_wd;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reload();
        @(negedge clk); preload = 1'b1;
        @(negedge clk); preload = 1'b0;
    endtask

    // lat: rsp_valid cycle counted from the accept edge (2 or 3).
    task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int lat, input int exp_writes);
        int w0;
        w0 = we_cnt;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        chk({name, "_ready"}, {31'h0, bus.req_ready}, 32'h1);
        @(posedge clk); #1;
        sb_q.push_back('{exp_rdata, exp_err, cyc + lat - 1, name});
        bus.req_valid = 1'b0;
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        if (sb_q.size() != 0) begin
            chk({name, "_timeout"}, sb_q.size(), 32'h0);
            sb_q.delete();
        end
        chk({name, "_writes"}, we_cnt - w0, exp_writes);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (bus.mem_we) we_cnt++;
                    if (rst_n && bus.rsp_valid) begin
                        rsp_cnt++;
                        if (sb_q.size() == 0) begin
                            chk("unexpected_rsp", 32'h1, 32'h0);
                        end else begin
                            e = sb_q.pop_front();
                            chk({e.name, "_rdata"}, bus.rsp_rdata, e.rdata);
                            chk({e.name, "_err"}, {31'h0, bus.rsp_err}, {31'h0, e.err});
                            chk({e.name, "_cycle"}, cyc, e.cyc);
                        end
                    end
                end
            end
        join_none

        // Reset values while rst_n is held low.
        reload();
        #1;
        chk("rst_ready",     {31'h0, bus.req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("rst_rdata",     bus.rsp_rdata, 32'h0);
        chk("rst_err",       {31'h0, bus.rsp_err}, 32'h0);
        chk("rst_mem_we",    {31'h0, bus.mem_we}, 32'h0);
        chk("rst_mem_wd",    bus.mem_wd, 32'h0);
        chk("rst_mem_a",     bus.mem_a, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // Loads from 0x10 = 0x8899AABB.
        do_req("lb_13",  1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 2, 0);
        do_req("lhu_12", 1'b0, F3_HU, 32'h12, 32'h0, 32'h00008899, 1'b0, 2, 0);
        do_req("lh_10",  1'b0, F3_H,  32'h10, 32'h0, 32'hFFFFAABB, 1'b0, 2, 0);
        do_req("lbu_11", 1'b0, F3_BU, 32'h11, 32'h0, 32'h000000AA, 1'b0, 2, 0);
        do_req("lb_10",  1'b0, F3_B,  32'h10, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 0);
        do_req("lbu_13", 1'b0, F3_BU, 32'h13, 32'h0, 32'h00000088, 1'b0, 2, 0);
        do_req("lh_12",  1'b0, F3_H,  32'h12, 32'h0, 32'hFFFF8899, 1'b0, 2, 0);

        // Byte store read-modify-write.
        do_req("sb_11", 1'b1, F3_B, 32'h11, 32'hDEADBECC, 32'h0, 1'b0, 3, 1);
        chk("sb_11_mem", mem[4], 32'h8899CCBB);

        // Half store, then word store over it.
        reload();
        do_req("sh_12", 1'b1, F3_H, 32'h12, 32'h00001234, 32'h0, 1'b0, 3, 1);
        chk("sh_12_mem", mem[4], 32'h1234AABB);
        do_req("sw_10", 1'b1, F3_W, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1);
        chk("sw_10_mem", mem[4], 32'hCAFEF00D);
        do_req("l011_10", 1'b0, 3'b011, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0, 2, 0);

        // Reset asserted during the WRITE cycle of SB 0x10.
        reload();
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_B;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'h00000011;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstw_we_before", {31'h0, bus.mem_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rstw_we_after", {31'h0, bus.mem_we}, 32'h0);
        chk("rstw_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        repeat (2) @(negedge clk);
        chk("rstw_mem", mem[4], 32'h8899AABB);
        rst_n = 1'b1;
        #1;
        chk("rstw_ready", {31'h0, bus.req_ready}, 32'h1);

        // req_valid held through the busy period: one accept only.
        begin
            int r0;
            r0 = rsp_cnt;
            @(negedge clk);
            bus.req_valid  = 1'b1;
            bus.req_we     = 1'b0;
            bus.req_funct3 = F3_W;
            bus.req_addr   = 32'h10;
            chk("hold_ready", {31'h0, bus.req_ready}, 32'h1);
            @(posedge clk); #1;
            sb_q.push_back('{32'h8899AABB, 1'b0, cyc + 1, "hold_lw"});
            chk("hold_busy_ready", {31'h0, bus.req_ready}, 32'h0);
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            bus.req_valid = 1'b0;
            repeat (4) @(negedge clk);
            #1;
            chk("hold_rsp_count", rsp_cnt - r0, 32'h1);
        end

        // Misaligned accesses.
`ifdef MISALIGN_TRAP_EN
        do_req("lw_11", 1'b0, F3_W, 32'h11, 32'h0, 32'h0, 1'b1, 2, 0);
        do_req("lh_11", 1'b0, F3_H, 32'h11, 32'h0, 32'h0, 1'b1, 2, 0);
        do_req("sw_12", 1'b1, F3_W, 32'h12, 32'h55667788, 32'h0, 1'b1, 2, 0);
        chk("sw_12_mem", mem[4], 32'h8899AABB);
`else
        do_req("lw_11", 1'b0, F3_W, 32'h11, 32'h0, 32'h8899AABB, 1'b0, 2, 0);
        do_req("lh_11", 1'b0, F3_H, 32'h11, 32'h0, 32'hFFFFAABB, 1'b0, 2, 0);
        do_req("sw_12", 1'b1, F3_W, 32'h12, 32'h55667788, 32'h0, 1'b0, 2, 1);
        chk("sw_12_mem", mem[4], 32'h55667788);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store front-end between the multicycle datapath and the unified word-addressed memory. The memory has a combinational read on RD and a synchronous write on the posedge of clk when we=1. This block accepts one load/store request at a time through a valid/ready handshake. It drives the memory A/WD/we, sign- or zero-extends sub-word load data, and performs read-modify-write for byte and halfword stores, because the memory only writes whole words.

Parameters:
XLEN, 32, data/address width; only 32 is supported.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (IDLE)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  input  32  byte address
req_wdata  input  32  store data; low byte/half used for SB/SH
rsp_valid  output  1  one-cycle pulse: access complete
rsp_rdata  output  32  extended load data; 0 for stores
rsp_err  output  1  misaligned access (only with the feature; tied 0 otherwise)
mem_a  output  32  memory address, always {addr_q[31:2],2'b00}
mem_wd  output  32  memory write data
mem_we  output  1  memory write enable
mem_rd  input  32  memory read data (combinational)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; addr_q, wdata_q, merge_q and rdata_q = 0. Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_wd=0, mem_a=0.
- mem_we is decoded combinationally from state only. A reset in any state deasserts it immediately, and no partial write occurs.
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, funct3, we and wdata, then go to ACCESS.
- ACCESS:
  - mem_a is driven from addr_q.
  - Load: rdata_q <= extend(mem_rd). Go to RESP.
  - SW: mem_we=1 and mem_wd=wdata_q. Go to RESP.
  - SB/SH: merge_q <= mem_rd with lane(s) replaced by wdata_q. Go to WRITE.
- WRITE: mem_we=1, mem_wd=merge_q. Go to RESP.
- RESP: rsp_valid=1, rsp_rdata=rdata_q (0 for stores). Go to IDLE. No response backpressure.
- Latency, counted from the accept edge: rsp_valid is high in cycle +2 for loads and SW, and +3 for SB/SH.
- Byte lane = addr_q[1:0]. Half lane = addr_q[1].
- LB/LH sign-extend. LBU/LHU zero-extend.
- Undefined funct3 values (011, 110, 111) are treated as word accesses.
- Without the feature: misaligned addresses are silently truncated. LW/SW ignore addr[1:0]; LH/SH ignore addr[0].
- req_valid while not in IDLE is ignored. The next request is accepted in IDLE on the cycle after RESP.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: in ACCESS, a word access with addr_q[1:0]!=0, or a half access with addr_q[0]=1, performs no memory write and captures no data. The block goes straight to RESP with rsp_err=1 and rsp_rdata=0.
- Undefined: rsp_err is tied to 0 and the truncation behaviour above applies.

Decomposition:
- Package mem_access_pkg holds:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101;
  - the state enum (IDLE/ACCESS/WRITE/RESP).
- One combinational sub-module, load_extend (inputs: word, funct3, addr[1:0]; output: extended 32-bit data), reused by the core's writeback stage.
- Store merge logic stays inline.

Test Plan:
Preload mem word at 0x10 = 0x8899AABB for all scenarios.
- LB 0x13 → rsp_rdata=0xFFFFFF88, rsp_valid 2 cycles after accept, mem_we never high.
- LHU 0x12 → 0x00008899. LH 0x10 → 0xFFFFAABB. LBU 0x11 → 0x000000AA.
- SB 0x11, wdata 0xDEADBECC → word becomes 0x8899CCBB, mem_we high exactly one cycle (WRITE), rsp_valid at +3.
- SH 0x12, wdata 0x00001234 → word becomes 0x1234AABB. Then SW 0x10, wdata 0xCAFEF00D → word becomes 0xCAFEF00D at +1, rsp at +2.
- rst pulled low during WRITE of SB 0x10 → mem_we drops the same cycle, word stays 0x8899AABB, req_ready=1 after release. Held req_valid during a busy period is not double-accepted.
- LW 0x11:
  - with MISALIGN_TRAP_EN: rsp_err=1, rsp_rdata=0, no write;
  - without it: rsp_rdata=0x8899AABB, rsp_err=0.
